// File: rtl/pc_branch_unit.sv
// Program counter with PC-relative branch, absolute jump, call/return via a LIFO return stack, and stall.
// One-cycle latency from sampled control to pc; stall freezes pc, stack and error flags. Optional stats: PC_BRANCH_STATS_EN.
module pc_branch_unit #(
    parameter int            AW       = 8,
    parameter int            DEPTH    = 4,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          branch_en,
    input  logic          branch_taken,
    input  logic [AW-1:0] offset,
    input  logic          jump_en,
    input  logic          call_en,
    input  logic          ret_en,
    input  logic [AW-1:0] jump_addr,
    output logic [AW-1:0] pc,
    output logic          pc_valid,
    output logic          stack_full,
    output logic          stack_empty,
    output logic          err_ovf,
    output logic          err_unf
`ifdef PC_BRANCH_STATS_EN
    ,
    output logic [7:0]    taken_cnt
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic [AW-1:0] stack_q [DEPTH];
    logic [AW-1:0] stack_d [DEPTH];

    logic [AW-1:0] pc_inc;
    logic [PW-1:0] top_idx;
    logic          active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == IDLE) state_d = RUN;
    end

    always_comb begin
        pc_valid = (state_q == RUN);
    end

    assign stack_empty = (cnt_q == '0);
    assign stack_full  = (cnt_q == FULL_CNT);
    assign pc_inc      = pc_q + AW'(1);
    // When full the low pointer bits wrap to 0, so subtracting one still lands on the top slot.
    assign top_idx     = cnt_q[PW-1:0] - PW'(1);
    assign active      = (state_q == RUN) && !stall;

    always_comb begin
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        stack_d = stack_q;
        if (active) begin
            if (ret_en) begin
                if (!stack_empty) begin
                    pc_d  = stack_q[top_idx];
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    pc_d  = pc_inc;
                    unf_d = 1'b1;
                end
            end else if (call_en) begin
                if (!stack_full) begin
                    stack_d[cnt_q[PW-1:0]] = pc_inc;
                    cnt_d = cnt_q + CW'(1);
                    pc_d  = jump_addr;
                end else begin
                    pc_d  = pc_inc;
                    ovf_d = 1'b1;
                end
            end else if (jump_en) begin
                pc_d = jump_addr;
            end else if (branch_en && branch_taken) begin
                pc_d = pc_inc + offset;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= RESET_PC;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Entry contents are meaningless while the count excludes them, so no reset.
    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end

    assign pc      = pc_q;
    assign err_ovf = ovf_q;
    assign err_unf = unf_q;

`ifdef PC_BRANCH_STATS_EN
    logic       redirect;
    logic [7:0] taken_cnt_q, taken_cnt_d;

    always_comb begin
        redirect = 1'b0;
        if (active) begin
            if (ret_en)                      redirect = !stack_empty;
            else if (call_en)                redirect = !stack_full;
            else if (jump_en)                redirect = 1'b1;
            else if (branch_en && branch_taken) redirect = 1'b1;
        end
    end

    always_comb begin
        taken_cnt_d = taken_cnt_q;
        if (redirect && (taken_cnt_q != 8'hFF)) taken_cnt_d = taken_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) taken_cnt_q <= 8'd0;
        else        taken_cnt_q <= taken_cnt_d;
    end

    assign taken_cnt = taken_cnt_q;
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit: expected outputs queued per step, popped and checked after each edge.
module tb_pc_branch_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       stall, branch_en, branch_taken, jump_en, call_en, ret_en;
    logic [7:0] offset, jump_addr;
    logic [7:0] pc;
    logic       pc_valid, stack_full, stack_empty, err_ovf, err_unf;
`ifdef PC_BRANCH_STATS_EN
    logic [7:0] taken_cnt;
`endif

    pc_branch_unit dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .branch_en(branch_en), .branch_taken(branch_taken), .offset(offset),
        .jump_en(jump_en), .call_en(call_en), .ret_en(ret_en), .jump_addr(jump_addr),
        .pc(pc), .pc_valid(pc_valid), .stack_full(stack_full), .stack_empty(stack_empty),
        .err_ovf(err_ovf), .err_unf(err_unf)
`ifdef PC_BRANCH_STATS_EN
        , .taken_cnt(taken_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] pc;
        logic       vld;
        logic       full;
        logic       empty;
        logic       ovf;
        logic       unf;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_chk  = 0;

    task automatic cmp(input string tag, input string fld, input logic [7:0] got, input logic [7:0] want);
        n_chk++;
        assert (got === want) n_pass++;
        else $error("FAIL %s.%s got %h expected %h", tag, fld, got, want);
    endtask

    task automatic push_exp(input logic [7:0] e_pc, input logic e_vld, e_full, e_empty, e_ovf, e_unf);
        exp_t e;
        e = '{pc: e_pc, vld: e_vld, full: e_full, empty: e_empty, ovf: e_ovf, unf: e_unf};
        exp_q.push_back(e);
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_chk++;
            $error("FAIL %s scoreboard empty got pc %h expected a queued entry", tag, pc);
            return;
        end
        e = exp_q.pop_front();
        cmp(tag, "pc",    pc,                 e.pc);
        cmp(tag, "vld",   {7'd0, pc_valid},    {7'd0, e.vld});
        cmp(tag, "full",  {7'd0, stack_full},  {7'd0, e.full});
        cmp(tag, "empty", {7'd0, stack_empty}, {7'd0, e.empty});
        cmp(tag, "ovf",   {7'd0, err_ovf},     {7'd0, e.ovf});
        cmp(tag, "unf",   {7'd0, err_unf},     {7'd0, e.unf});
    endtask

    task automatic drive(input logic st, br, tk, jmp, cl, rt, input logic [7:0] off, ja);
        stall = st; branch_en = br; branch_taken = tk;
        jump_en = jmp; call_en = cl; ret_en = rt;
        offset = off; jump_addr = ja;
    endtask

    // One clock: drive controls, queue the expected post-edge state, then compare 1 time unit after the edge.
    task automatic step(input logic st, br, tk, jmp, cl, rt, input logic [7:0] off, ja,
                        input logic [7:0] e_pc, input logic e_full, e_empty, e_ovf, e_unf,
                        input string tag);
        drive(st, br, tk, jmp, cl, rt, off, ja);
        push_exp(e_pc, 1'b1, e_full, e_empty, e_ovf, e_unf);
        @(posedge clk);
        #1;
        check_out(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        #12;
        push_exp(8'h00, 0, 0, 1, 0, 0);
        check_out("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        push_exp(8'h00, 0, 0, 1, 0, 0);
        check_out("idle_after_release");
        @(posedge clk);
        #1;

        // first edge after release only enters RUN; pc starts counting on the next edge
        drive(0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        push_exp(8'h00, 1, 0, 1, 0, 0);
        check_out("run_entry");
        step(0,0,0,0,0,0, 8'h00, 8'h00,  8'h01, 0,1,0,0, "inc1");
        step(0,0,0,0,0,0, 8'h00, 8'h00,  8'h02, 0,1,0,0, "inc2");

        step(0,0,0,1,0,0, 8'h00, 8'h10,  8'h10, 0,1,0,0, "jump10");
        step(0,1,1,0,0,0, 8'hFD, 8'h00,  8'h0E, 0,1,0,0, "br_back3");
        step(0,0,0,1,0,0, 8'h00, 8'h10,  8'h10, 0,1,0,0, "jump10b");
        step(0,1,0,0,0,0, 8'hFD, 8'h00,  8'h11, 0,1,0,0, "br_not_taken");
        step(0,0,0,1,0,0, 8'h00, 8'hFE,  8'hFE, 0,1,0,0, "jumpFE");
        step(0,1,1,0,0,0, 8'h03, 8'h00,  8'h02, 0,1,0,0, "br_wrap_fwd");
        step(0,0,0,1,0,0, 8'h00, 8'hFF,  8'hFF, 0,1,0,0, "jumpFF");
        step(0,0,0,0,0,0, 8'h00, 8'h00,  8'h00, 0,1,0,0, "inc_wrap");

        step(0,0,0,1,0,0, 8'h00, 8'h20,  8'h20, 0,1,0,0, "jump20");
        step(0,0,0,0,1,0, 8'h00, 8'h80,  8'h80, 0,0,0,0, "call80");
        step(0,0,0,0,0,0, 8'h00, 8'h00,  8'h81, 0,0,0,0, "in_sub1");
        step(0,0,0,0,0,0, 8'h00, 8'h00,  8'h82, 0,0,0,0, "in_sub2");
        step(0,0,0,0,0,1, 8'h00, 8'h00,  8'h21, 0,1,0,0, "ret21");

        // stall beats everything; then call+ret together resolves to a plain return
        step(0,0,0,0,1,0, 8'h00, 8'h60,  8'h60, 0,0,0,0, "call60");
        step(1,0,0,0,1,1, 8'h00, 8'h99,  8'h60, 0,0,0,0, "stall_call_ret");
        step(1,1,1,1,0,0, 8'h05, 8'h99,  8'h60, 0,0,0,0, "stall_jump");
        step(0,0,0,0,1,1, 8'h00, 8'h99,  8'h22, 0,1,0,0, "call_ret_same");

        step(0,0,0,0,1,0, 8'h00, 8'h30,  8'h30, 0,0,0,0, "nest1");
        step(0,0,0,0,1,0, 8'h00, 8'h31,  8'h31, 0,0,0,0, "nest2");
        step(0,0,0,0,1,0, 8'h00, 8'h32,  8'h32, 0,0,0,0, "nest3");
        step(0,0,0,0,1,0, 8'h00, 8'h40,  8'h40, 1,0,0,0, "nest4_full");
        step(0,0,0,0,1,0, 8'h00, 8'h90,  8'h41, 1,0,1,0, "call_ovf");
        step(0,0,0,0,0,1, 8'h00, 8'h00,  8'h33, 0,0,1,0, "pop1");
        step(0,0,0,0,0,1, 8'h00, 8'h00,  8'h32, 0,0,1,0, "pop2");
        step(0,0,0,0,0,1, 8'h00, 8'h00,  8'h31, 0,0,1,0, "pop3");
        step(0,0,0,0,0,1, 8'h00, 8'h00,  8'h23, 0,1,1,0, "pop4");
        step(0,0,0,0,0,1, 8'h00, 8'h00,  8'h24, 0,1,1,1, "ret_unf");
        step(1,0,0,0,0,1, 8'h00, 8'h00,  8'h24, 0,1,1,1, "stall_ret_empty");
        step(0,0,0,0,0,0, 8'h00, 8'h00,  8'h25, 0,1,1,1, "sticky_inc");

        step(0,1,1,1,0,0, 8'h05, 8'h70,  8'h70, 0,1,1,1, "jump_over_branch");
        step(0,0,0,1,0,0, 8'h00, 8'h01,  8'h01, 0,1,1,1, "jump01");
        step(0,1,1,0,0,0, 8'hFD, 8'h00,  8'hFF, 0,1,1,1, "br_wrap_back");
        step(0,1,1,0,0,0, 8'h01, 8'h00,  8'h01, 0,1,1,1, "br_from_FF");
        step(0,0,0,0,1,0, 8'h00, 8'hA0,  8'hA0, 0,0,1,1, "call_A0");

        // asynchronous reset mid-operation with stall and controls still asserted
        drive(1, 1, 1, 1, 1, 1, 8'h05, 8'h55);
        rst_n = 1'b0;
        #2;
        push_exp(8'h00, 0, 0, 1, 0, 0);
        check_out("async_reset");
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_exp(8'h00, 1, 0, 1, 0, 0);
        check_out("rerun_entry");
        step(0,0,0,0,0,0, 8'h00, 8'h00,  8'h01, 0,1,0,0, "rerun_inc");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pc_branch_unit.md
Name: pc_branch_unit

Overview:
- Program-counter stage of the 8-bit datapath; sits directly downstream of the 3-bit-to-8-bit immediate sign extender.
- Consumes the 8-bit sign-extended offset for PC-relative branches, and also supports absolute jumps, call/return through a small hardware return stack, and stalls.
- Drives the instruction-memory address each cycle.

Parameters:
AW, 8, PC and address width in bits
DEPTH, 4, return-stack entries (power of two, 2..16)
RESET_PC, 8'h00, PC value loaded on reset

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  freeze PC and stack this cycle
branch_en  in  1  current instruction is a conditional branch
branch_taken  in  1  branch condition result (qualified by branch_en)
offset  in  AW  sign-extended branch offset from sign extender, two's complement
jump_en  in  1  absolute jump
call_en  in  1  call: push return address, go to jump_addr
ret_en  in  1  return: pop return stack into PC
jump_addr  in  AW  absolute target for jump/call
pc  out  AW  current program counter
pc_valid  out  1  PC is fetch-valid
stack_full  out  1  return stack holds DEPTH entries
stack_empty  out  1  return stack holds 0 entries
err_ovf  out  1  sticky: call attempted while stack full
err_unf  out  1  sticky: return attempted while stack empty

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, pc_valid=0, stack count=0, stack_empty=1, stack_full=0, err_ovf=0, err_unf=0, FSM=IDLE. Stack storage contents are don't-care.
- FSM states:
  - IDLE: pc held, all controls ignored. Goes to RUN on the first rising edge after rst_n deasserts. pc_valid=0 while in IDLE.
  - RUN: pc_valid=1. Leaves RUN only via reset.
- All updates are registered. A control sampled on edge N is visible on pc after edge N, giving one-cycle latency.
- RUN priority, highest first:
  1. stall=1: pc, stack and error flags all hold. Every other input is ignored, including illegal call/ret.
  2. ret_en:
     - stack non-empty: pc <= top entry; count-1.
     - stack empty: pc <= pc+1; err_unf <= 1.
  3. call_en:
     - stack not full: push pc+1 (mod 2^AW); pc <= jump_addr.
     - stack full: no push; pc <= pc+1; err_ovf <= 1.
  4. jump_en: pc <= jump_addr.
  5. branch_en & branch_taken: pc <= pc + 1 + offset, modulo 2^AW. offset is signed, so 8'hFF means -1.
  6. Otherwise, including branch_en with branch_taken=0: pc <= pc+1.
- Simultaneous call_en and ret_en: return wins; the call is dropped with no error.
- Arithmetic: every PC sum is truncated to AW bits, so wrap-around is silent (8'hFF+1 = 8'h00). A branch to pc+1+offset that crosses 0 wraps and is not an error.
- Return stack is LIFO, implemented as a pointer plus register array. stack_full and stack_empty are combinational from the count.
- err_ovf and err_unf are sticky until reset.
- Reset asserted mid-operation immediately returns every output to its reset value, regardless of stall or pending controls.

Optional Feature:
- Macro: PC_BRANCH_STATS_EN.
- Defined: adds output taken_cnt [7:0].
  - Increments on each executed redirect (taken branch, jump, successful call, successful return). Not incremented while stalled.
  - Saturates at 8'hFF.
  - Resets to 0.
- Undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset release: rst_n low then high; no controls -> pc=8'h00, pc_valid=0 for one cycle; then pc=00,01,02 on successive edges with pc_valid=1.
- Branch: pc=8'h10, branch_en=1, branch_taken=1, offset=8'hFD (-3) -> pc=8'h0E. Same with branch_taken=0 -> pc=8'h11.
- Wrap: pc=8'hFE, taken branch offset=8'h03 -> pc=8'h02. pc=8'hFF with no control -> pc=8'h00.
- Call/return: at pc=8'h20, call_en with jump_addr=8'h80 -> pc=80, stack count 1. Idle to pc=82, then ret_en -> pc=8'h21, stack_empty=1.
- Overflow/underflow: 4 nested calls fill the stack (stack_full=1); a 5th call at pc=8'h40 -> pc=8'h41, err_ovf=1. Pop 4 times, then a 5th ret -> pc increments, err_unf=1. Both flags stay high until rst_n.
- Stall/priority: stall=1 with call_en and ret_en both high -> pc, count and flags unchanged. Drop stall, keep call_en and ret_en -> return executes, no push, no error.
